sound_fx_seq: RTL and testbench
===============================

SOUND_FX_SEQ -- requirements
Module: sound_fx_seq

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter NUM_FX, default 4, number of sound effects (1..8).
REQ-003 Parameter SEQ_LEN, default 8, note slots per effect (2..16).
REQ-004 Parameter NOTE_CYC, default 12500000, clock cycles per note slot (125 ms at default clock).
REQ-005 Parameter GAP_CYC, default 100000, silent cycles after each note slot (GAP_CYC < NOTE_CYC).
REQ-006 clk  input  1  system clock; all state on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 trig  input  NUM_FX  one-cycle start requests; bit i requests effect i.
REQ-009 enable  input  1  1 = audible; 0 = speaker muted, sequencing unaffected.
REQ-010 speaker_out  output  1  registered square-wave speaker drive.
REQ-011 busy  output  1  high while an effect is playing (PLAY or GAP).
REQ-012 fx_id  output  3  index of the current or last-played effect.

Function
REQ-013 The note code is 3 bits: 0 rest, 1 A3 220 Hz, 2 A4 440, 3 C5 523, 4 E5 659, 5 G5 784, 6 A5 880, 7 C6 1047.
REQ-014 Half-period for note f SHALL be CLK_HZ/(2*f), truncated, held in a counter at least 24 bits wide.
REQ-015 Effect ROM: fx0 = 6,5,4,3,2,1,0,0; fx1 = 7,0,7,0,…; fx2 = 2,3,4,5,…; fx3 = 3,4,5,7,7,…. Patterns repeat or zero-fill to SEQ_LEN; effects >= 4 mirror fx(i mod 4).
REQ-016 FSM states: IDLE, PLAY, GAP.
REQ-017 IDLE with any trig bit set -> PLAY on the next edge.
  - Lowest set bit wins; fx_id takes that index.
  - Slot index = 0; note and tone counters reload.
REQ-018 PLAY lasts exactly NOTE_CYC - GAP_CYC cycles, then -> GAP.
REQ-019 GAP lasts exactly GAP_CYC cycles, then:
  - last slot (SEQ_LEN-1) -> IDLE;
  - otherwise slot + 1 -> PLAY.
REQ-020 In PLAY with a non-rest note, speaker_out SHALL toggle every half-period cycles.
  - The tone counter reloads to half-period-1 at each toggle and at slot start.
  - The first toggle occurs half-period cycles after PLAY entry.
REQ-021 speaker_out SHALL be 0 in IDLE, in GAP, during rest notes, and whenever enable = 0.
  - It is forced to 0 on the cycle of the state change.
REQ-022 Trigger while busy:
  - If the lowest set bit index < fx_id, SHALL restart from slot 0 with that effect (preempt).
  - Otherwise the trigger is ignored (no queuing).
REQ-023 A trigger arriving on the same cycle as GAP->IDLE of the last slot SHALL be accepted as if in IDLE (busy stays high).
REQ-024 busy SHALL be registered and equal (state != IDLE).
REQ-025 fx_id SHALL hold its value in IDLE.
REQ-026 A trig held high for multiple cycles is not re-accepted unless REQ-022 or REQ-023 applies.

Reset
REQ-027 While reset is 1, all of the following hold:
  - state = IDLE
  - speaker_out = 0
  - busy = 0
  - fx_id = 0
  - all counters and the slot index = 0
REQ-028 Reset asserted mid-effect SHALL abort immediately (asynchronously).
  - No resume after release.
  - The first edge after release with trig set starts normally.

Verification (CLK_HZ=88000, NOTE_CYC=1000, GAP_CYC=100, SEQ_LEN=8, NUM_FX=4)
REQ-029 trig=4'b0001 one cycle, enable=1:
  - busy rises next edge, fx_id=0.
  - Slot 0 (A5) toggles every 50 cycles for 900 cycles, then 100 cycles low.
  - busy falls 8000 cycles after start.
REQ-030 trig=4'b0100 (fx2, slot 0 A4): speaker_out toggles every 100 cycles (period 200); slot 1 (C5) toggles every 84 cycles.
REQ-031 During fx2 slot 3, trig=4'b0001 -> restart, fx_id=0, slot 0 A5; trig=4'b1000 during fx0 is ignored.
REQ-032 trig=4'b0110 -> fx_id=1; rest slots hold speaker_out=0 for all 1000 cycles; enable=0 mid-note -> speaker_out=0 next edge while busy/timing unchanged.
REQ-033 Assert reset 300 cycles into fx0 -> speaker_out=0, busy=0 immediately; after release, idle until the next trig.
REQ-034 trig pulse coincident with final GAP->IDLE edge -> busy stays 1, new effect slot 0 begins on that edge.

Source files
------------

// File: rtl/sound_fx_seq_if.sv
// Control/status bundle for the sound effect sequencer: trigger and mute
// requests in, speaker drive and playback status out.
`timescale 1ns/1ps
interface sound_fx_seq_if #(
  parameter int NUM_FX = 4
);
  logic [NUM_FX-1:0] trig;
  logic              enable;
  logic              speaker_out;
  logic              busy;
  logic [2:0]        fx_id;

  modport master (
    output trig, enable,
    input  speaker_out, busy, fx_id
  );

  modport slave (
    input  trig, enable,
    output speaker_out, busy, fx_id
  );
endinterface

// File: rtl/sound_fx_seq.sv
// Plays short fixed note sequences as a square wave on a single speaker pin;
// lower-numbered effects take priority over the one currently playing.
`timescale 1ns/1ps
module sound_fx_seq #(
  parameter int CLK_HZ   = 100000000,
  parameter int NUM_FX   = 4,
  parameter int SEQ_LEN  = 8,
  parameter int NOTE_CYC = 12500000,
  parameter int GAP_CYC  = 100000
) (
  input logic           clk,
  input logic           reset,
  sound_fx_seq_if.slave bus
);

  localparam int NOTE_W = $clog2(NOTE_CYC + 1);
  localparam int TONE_W = 24;
  localparam logic [NOTE_W-1:0] PLAY_LAST = NOTE_W'(NOTE_CYC - GAP_CYC - 1);
  localparam logic [NOTE_W-1:0] GAP_LAST  = NOTE_W'(GAP_CYC - 1);
  localparam logic [3:0]        SLOT_LAST = 4'(SEQ_LEN - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state, state_d;
  logic [3:0]          slot, slot_d;
  logic [2:0]          fx_id_q, fx_id_d;
  logic [NOTE_W-1:0]   note_cnt, note_cnt_d;
  logic [TONE_W-1:0]   tone_cnt, tone_cnt_d;
  logic                phase, phase_d;
  logic                speaker_q, speaker_d;
  logic                busy_q;
  logic                trig_any;
  logic [2:0]          trig_idx;
  logic                accept;
  logic                last_gap_end;
  logic [2:0]          note_cur;

  // Effects 4..7 reuse the four base patterns, so only the low two bits matter.
  function automatic logic [2:0] note_of(input logic [1:0] fx, input logic [3:0] s);
    logic [2:0] n;
    n = 3'd0;
    case (fx)
      2'd0: if (s < 4'd6) n = 3'd6 - s[2:0];
      2'd1: n = s[0] ? 3'd0 : 3'd7;
      2'd2: n = 3'd2 + {1'b0, s[1:0]};
      default: begin
        case (s)
          4'd0:    n = 3'd3;
          4'd1:    n = 3'd4;
          4'd2:    n = 3'd5;
          default: n = 3'd7;
        endcase
      end
    endcase
    return n;
  endfunction

  function automatic logic [TONE_W-1:0] half_m1(input logic [2:0] n);
    logic [TONE_W-1:0] h;
    case (n)
      3'd1:    h = TONE_W'(CLK_HZ / 440 - 1);
      3'd2:    h = TONE_W'(CLK_HZ / 880 - 1);
      3'd3:    h = TONE_W'(CLK_HZ / 1046 - 1);
      3'd4:    h = TONE_W'(CLK_HZ / 1318 - 1);
      3'd5:    h = TONE_W'(CLK_HZ / 1568 - 1);
      3'd6:    h = TONE_W'(CLK_HZ / 1760 - 1);
      3'd7:    h = TONE_W'(CLK_HZ / 2094 - 1);
      default: h = '0;
    endcase
    return h;
  endfunction

  // Lowest set trigger bit wins.
  always_comb begin
    trig_any = |bus.trig;
    trig_idx = '0;
    for (int i = NUM_FX - 1; i >= 0; i--) begin
      if (bus.trig[i]) trig_idx = 3'(i);
    end
  end

  assign note_cur = note_of(fx_id_q[1:0], slot);

  always_comb begin
    state_d      = state;
    slot_d       = slot;
    fx_id_d      = fx_id_q;
    note_cnt_d   = note_cnt;
    tone_cnt_d   = tone_cnt;
    phase_d      = phase;
    last_gap_end = 1'b0;

    case (state)
      PLAY: begin
        if (note_cnt == '0) begin
          state_d    = GAP;
          note_cnt_d = GAP_LAST;
          phase_d    = 1'b0;
        end else begin
          note_cnt_d = note_cnt - NOTE_W'(1);
          if (tone_cnt == '0) begin
            tone_cnt_d = half_m1(note_cur);
            phase_d    = ~phase;
          end else begin
            tone_cnt_d = tone_cnt - TONE_W'(1);
          end
        end
      end
      GAP: begin
        if (note_cnt == '0) begin
          if (slot == SLOT_LAST) begin
            state_d      = IDLE;
            last_gap_end = 1'b1;
          end else begin
            state_d    = PLAY;
            slot_d     = slot + 4'd1;
            note_cnt_d = PLAY_LAST;
            tone_cnt_d = half_m1(note_of(fx_id_q[1:0], slot + 4'd1));
          end
        end else begin
          note_cnt_d = note_cnt - NOTE_W'(1);
        end
      end
      default: ;
    endcase

    // A start on the final gap edge behaves like a start from IDLE, keeping busy high.
    accept = trig_any && ((state == IDLE) || last_gap_end || (trig_idx < fx_id_q));
    if (accept) begin
      state_d    = PLAY;
      fx_id_d    = trig_idx;
      slot_d     = '0;
      note_cnt_d = PLAY_LAST;
      tone_cnt_d = half_m1(note_of(trig_idx[1:0], 4'd0));
      phase_d    = 1'b0;
    end

    speaker_d = bus.enable && (state == PLAY) && (state_d == PLAY) && !accept &&
                (note_cur != 3'd0) && phase_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      slot      <= '0;
      fx_id_q   <= '0;
      note_cnt  <= '0;
      tone_cnt  <= '0;
      phase     <= 1'b0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      slot      <= slot_d;
      fx_id_q   <= fx_id_d;
      note_cnt  <= note_cnt_d;
      tone_cnt  <= tone_cnt_d;
      phase     <= phase_d;
      speaker_q <= speaker_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.speaker_out = speaker_q;
  assign bus.busy        = busy_q;
  assign bus.fx_id       = fx_id_q;

endmodule

// File: tb/tb_sound_fx_seq.sv
// Directed scoreboard bench for sound_fx_seq at a small clock so that note
// half-periods land on easy integers (A5 = 50 cycles, A4 = 100, C5 = 84).
`timescale 1ns/1ps
module tb_sound_fx_seq;

  localparam int NUM_FX = 4;

  typedef struct {
    string      tag;
    int         cyc;
    logic       spk;
    logic       busy;
    logic [2:0] fx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  sound_fx_seq_if #(.NUM_FX(NUM_FX)) bus ();

  sound_fx_seq #(
    .CLK_HZ  (88000),
    .NUM_FX  (NUM_FX),
    .SEQ_LEN (8),
    .NOTE_CYC(1000),
    .GAP_CYC (100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic spk, input logic bsy,
                             input logic [2:0] fx);
    checks++;
    assert ({bus.speaker_out, bus.busy, bus.fx_id} === {spk, bsy, fx}) else begin
      failures++;
      $error("[TB] FAIL %s @cyc %0d: got spk=%b busy=%b fx=%0d, want spk=%b busy=%b fx=%0d",
             tag, cyc, bus.speaker_out, bus.busy, bus.fx_id, spk, bsy, fx);
    end
  endtask

  task automatic expectAt(input string tag, input int at, input logic spk, input logic bsy,
                          input logic [2:0] fx);
    exp_t e;
    e.tag  = tag;
    e.cyc  = at;
    e.spk  = spk;
    e.busy = bsy;
    e.fx   = fx;
    sb.push_back(e);
  endtask

  // Expected results are consumed on the falling edge after the cycle they name.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checkOutput(e.tag, e.spk, e.busy, e.fx);
    end
  end

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NUM_FX-1:0] t, output int start);
    bus.trig = t;
    start    = cyc + 1;
  endtask

  task automatic releaseTrig();
    @(negedge clk);
    bus.trig = '0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached with %0d checks pending", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, e1, e2, base;
    bus.trig   = '0;
    bus.enable = 1'b1;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] fx0 full run");
    applyStimulus(4'b0001, e0);
    expectAt("fx0_busy_rise",    e0,        1'b0, 1'b1, 3'd0);
    expectAt("fx0_pre_toggle",   e0 + 49,   1'b0, 1'b1, 3'd0);
    expectAt("fx0_first_toggle", e0 + 50,   1'b1, 1'b1, 3'd0);
    expectAt("fx0_second_tog",   e0 + 100,  1'b0, 1'b1, 3'd0);
    expectAt("fx0_play_end",     e0 + 899,  1'b1, 1'b1, 3'd0);
    expectAt("fx0_gap_low",      e0 + 900,  1'b0, 1'b1, 3'd0);
    expectAt("fx0_gap_end",      e0 + 999,  1'b0, 1'b1, 3'd0);
    expectAt("fx0_g5_pre",       e0 + 1055, 1'b0, 1'b1, 3'd0);
    expectAt("fx0_g5_toggle",    e0 + 1056, 1'b1, 1'b1, 3'd0);
    expectAt("fx0_rest_slot",    e0 + 6500, 1'b0, 1'b1, 3'd0);
    expectAt("fx0_last_cycle",   e0 + 7999, 1'b0, 1'b1, 3'd0);
    expectAt("fx0_busy_fall",    e0 + 8000, 1'b0, 1'b0, 3'd0);
    releaseTrig();
    waitUntil(e0 + 8010);

    $display("[TB] fx2 tones and preemption");
    applyStimulus(4'b0100, e0);
    expectAt("fx2_start",        e0,        1'b0, 1'b1, 3'd2);
    expectAt("fx2_a4_pre",       e0 + 99,   1'b0, 1'b1, 3'd2);
    expectAt("fx2_a4_toggle",    e0 + 100,  1'b1, 1'b1, 3'd2);
    expectAt("fx2_a4_period",    e0 + 200,  1'b0, 1'b1, 3'd2);
    expectAt("fx2_c5_pre",       e0 + 1083, 1'b0, 1'b1, 3'd2);
    expectAt("fx2_c5_toggle",    e0 + 1084, 1'b1, 1'b1, 3'd2);
    expectAt("fx2_c5_period",    e0 + 1168, 1'b0, 1'b1, 3'd2);
    expectAt("fx2_slot3_g5",     e0 + 3199, 1'b1, 1'b1, 3'd2);
    releaseTrig();
    waitUntil(e0 + 3199);
    applyStimulus(4'b0001, e1);
    expectAt("preempt_restart",  e1,        1'b0, 1'b1, 3'd0);
    expectAt("preempt_a5",       e1 + 50,   1'b1, 1'b1, 3'd0);
    releaseTrig();
    waitUntil(e1 + 99);
    applyStimulus(4'b1000, e2);
    expectAt("low_prio_ignored", e2,        1'b0, 1'b1, 3'd0);
    expectAt("low_prio_tone",    e1 + 150,  1'b1, 1'b1, 3'd0);
    expectAt("preempt_done",     e1 + 8000, 1'b0, 1'b0, 3'd0);
    releaseTrig();
    waitUntil(e1 + 8010);

    $display("[TB] fx1 rests and muting");
    applyStimulus(4'b0110, e0);
    expectAt("fx1_lowest_bit",   e0,        1'b0, 1'b1, 3'd1);
    expectAt("fx1_c6_pre",       e0 + 41,   1'b0, 1'b1, 3'd1);
    expectAt("fx1_c6_toggle",    e0 + 42,   1'b1, 1'b1, 3'd1);
    expectAt("rest_start",       e0 + 1000, 1'b0, 1'b1, 3'd1);
    expectAt("rest_mid",         e0 + 1500, 1'b0, 1'b1, 3'd1);
    expectAt("rest_end",         e0 + 1899, 1'b0, 1'b1, 3'd1);
    expectAt("slot2_toggle",     e0 + 2042, 1'b1, 1'b1, 3'd1);
    expectAt("before_mute",      e0 + 2050, 1'b1, 1'b1, 3'd1);
    releaseTrig();
    waitUntil(e0 + 2050);
    bus.enable = 1'b0;
    expectAt("mute_next_edge",   e0 + 2051, 1'b0, 1'b1, 3'd1);
    expectAt("mute_hold",        e0 + 2100, 1'b0, 1'b1, 3'd1);
    waitUntil(e0 + 2150);
    bus.enable = 1'b1;
    expectAt("unmute_phase",     e0 + 2151, 1'b1, 1'b1, 3'd1);
    expectAt("unmute_toggle",    e0 + 2168, 1'b0, 1'b1, 3'd1);
    expectAt("fx1_last_cycle",   e0 + 7999, 1'b0, 1'b1, 3'd1);
    expectAt("fx_id_hold_idle",  e0 + 8000, 1'b0, 1'b0, 3'd1);
    waitUntil(e0 + 8010);

    $display("[TB] trigger on final gap edge, then abort by reset");
    applyStimulus(4'b1000, e0);
    expectAt("fx3_start",        e0,        1'b0, 1'b1, 3'd3);
    expectAt("fx3_c5_toggle",    e0 + 84,   1'b1, 1'b1, 3'd3);
    expectAt("fx3_final_gap",    e0 + 7999, 1'b0, 1'b1, 3'd3);
    releaseTrig();
    waitUntil(e0 + 7999);
    applyStimulus(4'b0010, e1);
    expectAt("coincident_accept", e1,       1'b0, 1'b1, 3'd1);
    expectAt("coincident_tone",  e1 + 42,   1'b1, 1'b1, 3'd1);
    releaseTrig();
    waitUntil(e1 + 100);
    #2 reset = 1'b1;
    #1 checkOutput("async_abort", 1'b0, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_hold", 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] reset 300 cycles into fx0");
    applyStimulus(4'b0001, e0);
    expectAt("fx0_r_tone",       e0 + 250,  1'b1, 1'b1, 3'd0);
    expectAt("fx0_r_before",     e0 + 299,  1'b1, 1'b1, 3'd0);
    releaseTrig();
    waitUntil(e0 + 299);
    #2 reset = 1'b1;
    #1 checkOutput("reset_mid_fx0", 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    base = cyc;
    expectAt("idle_after_release", base + 10, 1'b0, 1'b0, 3'd0);
    expectAt("no_resume",          base + 60, 1'b0, 1'b0, 3'd0);
    waitUntil(base + 60);
    applyStimulus(4'b0100, e0);
    expectAt("restart_after_reset", e0,       1'b0, 1'b1, 3'd2);
    expectAt("restart_tone",       e0 + 100,  1'b1, 1'b1, 3'd2);
    releaseTrig();
    waitUntil(e0 + 105);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_drain: %0d entries pending, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
